// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared across the RISC-V core.
//   XLEN          - datapath width
//   OP_*          - major opcodes, common to the fetch unit and main_decoder
//   fetch_state_e - fetch FSM state encoding
//   fetch_entry_t - one instruction-buffer entry (instruction + its PC)
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory and decode-side signals of the
// fetch stage.
//   imem_req_valid/imem_req_ready/imem_addr : request channel to imem
//   imem_rsp_valid/imem_rsp_data            : response channel from imem
//   instr_valid/instr_ready                 : head-of-buffer handshake to decode
//   instr/op/instr_pc/instr_pc_plus4        : head entry presented to decode
// master: the fetch unit. slave: memory + decode environment.
interface instr_fetch_unit_if;
  import riscv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [6:0]      op;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] instr_pc_plus4;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, op, instr_pc, instr_pc_plus4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, op, instr_pc, instr_pc_plus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: synchronous instruction buffer, DEPTH entries of fetch_entry_t.
//   clk, rst_n   - clock, asynchronous active-low reset
//   flush_i      - empties the buffer; voids push/pop in the same cycle
//   push_i       - write push_data_i at the tail
//   pop_i        - drop the head entry
//   head_o       - registered head entry, all-zero while empty
//   count_o      - occupancy; empty_o / full_o status flags
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign do_pop  = pop_i & ~flush_i & ~empty_o;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage feeding main_decoder.
//   clk, rst_n          - clock, asynchronous active-low reset
//   redirect            - taken branch / jal from execute
//   redirect_pc         - redirect target (forced to word alignment)
//   bus (master)        - imem request/response and decode head signals
//   fetch_count         - pops since reset        (FETCH_PERF_EN only)
//   starve_count        - cycles decode waited    (FETCH_PERF_EN only)
// Optional feature macro: FETCH_PERF_EN adds the two performance counters.
// One imem request is outstanding at most; returned words are buffered with
// their PCs in fetch_fifo, whose head is presented to decode.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  instr_fetch_unit_if.master  bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         fetch_count,
  output logic [31:0]         starve_count
`endif
);

  localparam int unsigned   CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            stale_q, stale_d;

  logic [CW-1:0]   count;
  logic [CW-1:0]   occ_after;
  logic            push, pop, empty, full;
  fetch_entry_t    head, push_entry;

  assign pop = bus.instr_valid & bus.instr_ready;

  // While waiting on a non-stale response, fetch_pc has already advanced past
  // the outstanding request, so the request PC is fetch_pc - 4.
  assign push_entry = '{instr: bus.imem_rsp_data, pc: fetch_pc_q - XLEN'(4)};

  // Occupancy after this cycle's push/pop; a push only happens with room.
  assign occ_after = count + CW'(push) - CW'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stale_d    = stale_q;
    push       = 1'b0;

    case (state_q)
      FETCH_IDLE: begin
        if (count < DEPTH_C) state_d = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (bus.imem_req_ready) begin
          state_d    = FETCH_WAIT;
          fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
      end
      FETCH_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (stale_q) stale_d = 1'b0;
          else         push    = 1'b1;
          state_d = (occ_after < DEPTH_C) ? FETCH_REQ : FETCH_IDLE;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase

    // Redirect overrides everything above. The buffer is flushed by the FIFO
    // itself; here only the PC, the stale marker and the state are fixed up.
    // A response landing in the redirect cycle is the one being waited on, so
    // it is simply dropped rather than marking a later response stale.
    if (redirect) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      push       = 1'b0;
      case (state_q)
        FETCH_IDLE: state_d = FETCH_REQ;
        FETCH_REQ: begin
          if (bus.imem_req_ready) stale_d = 1'b1;
        end
        FETCH_WAIT: begin
          if (bus.imem_rsp_valid) begin
            state_d = FETCH_REQ;
            stale_d = 1'b0;
          end else begin
            stale_d = 1'b1;
          end
        end
        default: state_d = FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= RESET_PC;
      stale_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      stale_q    <= stale_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .empty_o     (empty),
    .full_o      (full)
  );

  assign bus.imem_req_valid = (state_q == FETCH_REQ);
  assign bus.imem_addr      = fetch_pc_q;
  assign bus.instr_valid    = ~empty;
  assign bus.instr          = head.instr;
  assign bus.op             = head.instr[6:0];
  assign bus.instr_pc       = head.pc;
  assign bus.instr_pc_plus4 = head.pc + XLEN'(4);

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, starve_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q  <= '0;
      starve_count_q <= '0;
    end else begin
      if (pop & ~redirect)                  fetch_count_q  <= fetch_count_q + 32'd1;
      if (bus.instr_ready & ~bus.instr_valid) starve_count_q <= starve_count_q + 32'd1;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign starve_count = starve_count_q;
`endif

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the single-cycle RISC-V core, directly upstream of `main_decoder`. Keeps the fetch PC and issues word requests to instruction memory with a valid/ready handshake. Buffers returned instructions with their PCs in a small FIFO and presents the head to decode, exposing `op` = `instr[6:0]` for `main_decoder`. Taken branches and jumps from execute redirect fetch, flush the buffer and discard the in-flight response.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `FIFO_DEPTH`, 2, instruction buffer entries (power of two, ≥2)
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `redirect`  in  1  taken branch or jal (`branch & zero | jump`)
- `redirect_pc`  in  32  redirect target
- `imem_req_valid`  out  1  fetch request
- `imem_req_ready`  in  1  memory accepts request
- `imem_addr`  out  32  word address of request
- `imem_rsp_valid`  in  1  response data valid
- `imem_rsp_data`  in  32  fetched instruction
- `instr_valid`  out  1  FIFO head valid
- `instr_ready`  in  1  decode consumes head
- `instr`  out  32  head instruction (0 when empty)
- `op`  out  7  `instr[6:0]`, to `main_decoder`
- `instr_pc`  out  32  PC of head (0 when empty)
- `instr_pc_plus4`  out  32  `instr_pc + 4`, mod 2^32

## Operation
- Registers: `fetch_pc` (reset `RESET_PC`), FSM state, `stale` flag, FIFO storage and count.
- The FSM has three states: IDLE, REQ and WAIT. At most one request is outstanding.
- IDLE → REQ when `count < FIFO_DEPTH`. Otherwise the FSM stays in IDLE.
- REQ: `imem_req_valid`=1 and `imem_addr`=`fetch_pc`. On `imem_req_ready`, go to WAIT and set `fetch_pc` to `fetch_pc+4`.
- WAIT: on `imem_rsp_valid`:
  - If `stale`=0, push {`imem_rsp_data`, request PC}. If `stale`=1, drop the response and clear `stale`.
  - Next state is REQ if space remains after the push, else IDLE.
- A response arriving in IDLE or REQ is ignored.
- Pop happens when `instr_valid & instr_ready`. Push and pop may occur in the same cycle.
- Redirect has priority over all other events in that cycle:
  - Flush the FIFO: count becomes 0 and any pop or push in that cycle is void.
  - Set `fetch_pc` to {`redirect_pc[31:2]`, 2'b00}.
  - In WAIT, set `stale`. The FSM stays in WAIT until the response arrives, then goes to REQ.
  - In REQ with `imem_req_ready`=1: the request is accepted, `stale` is set, the FSM goes to WAIT, and `fetch_pc` = redirect target (no +4).
  - In REQ with `imem_req_ready`=0: the FSM stays in REQ and `imem_addr` shows the new target next cycle. Memory tolerates the address change.
- `op` is 0 while empty, so the decoder sees its default opcode.

## Timing
- Reset values: `imem_req_valid`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr`/`op`/`instr_pc`=0, `instr_pc_plus4`=4, counters 0, state IDLE, `stale`=0.
- Asserting reset mid-operation clears all state immediately. Any late response is ignored because the FSM is in IDLE.
- First edge after `rst_n` rises: IDLE → REQ.
- Latency: a response accepted at edge N appears at `instr_valid` after edge N (one cycle). There is no bypass.
- With zero-wait memory (ready=1, response one cycle after accept), sustained throughput is one instruction per 2 cycles.
- FIFO outputs are registered head entries. `instr_pc_plus4` is combinational from `instr_pc`.

## Configuration
- `FETCH_PERF_EN` defined: adds two outputs, both wrapping at 2^32 and reset to 0.
  - `fetch_count` (out, 32) increments on each pop.
  - `starve_count` (out, 32) increments each cycle with `instr_ready & ~instr_valid`.
- `FETCH_PERF_EN` undefined: these ports and counters do not exist.

## Structure
- Shared `riscv_pkg` holds:
  - `XLEN`=32.
  - Opcode constants `OP_LOAD` 7'b0000011, `OP_STORE` 7'b0100011, `OP_RTYPE` 7'b0110011, `OP_ITYPE` 7'b0010011, `OP_BRANCH` 7'b1100011, `OP_JAL` 7'b1101111, used by both this block and `main_decoder`.
  - Fetch FSM state encoding.
- Sub-module `fetch_fifo`: synchronous FIFO, `FIFO_DEPTH` × 64 bits (instr + PC), with push, pop, flush, count, and empty/full.

## Test plan
- Reset release, `RESET_PC`=0, memory returns 0x00500093 at address 0 → `imem_addr`=0, then `instr_valid`=1 with `instr`=0x00500093, `op`=0x13, `instr_pc`=0, `instr_pc_plus4`=4.
- `instr_ready`=0 with a sequential program → exactly 2 entries buffered (PCs 0, 4). `imem_req_valid` then stays 0 until a pop.
- Redirect to 0x100 while in WAIT for PC 8 → the PC-8 response is dropped, the FIFO is flushed, and the next `instr_pc` is 0x100.
- Redirect to 0x202 in the same cycle as a request handshake → next fetch address is 0x200, the in-flight response is dropped, and no PC 0x204 skip occurs.
- Simultaneous push and pop with the FIFO full for one entry → count unchanged and order preserved (PCs strictly +4).
- Reset asserted in WAIT, then a response arrives → nothing is pushed, and fetch restarts at `RESET_PC`. With `FETCH_PERF_EN`, 10 pops give `fetch_count`=10.
